// File: rtl/seg_scan_if.sv
// Display data in and pin drive out for the seven-segment scan driver.
interface seg_scan_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic                    frame_sync;

    modport master (
        output data, dp, digit_en,
        input  an_n, seg_n, dp_n, frame_sync
    );

    modport slave (
        input  data, dp, digit_en,
        output an_n, seg_n, dp_n, frame_sync
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner: one digit per divider rising edge,
// blanking gap between digits, display data latched once per frame.
module seg_scan_driver #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BLANK_CYC  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_in,
    seg_scan_if.slave   bus
);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {S_BLANK, S_SHOW, S_DARK} state_t;

    state_t                  r_state, w_state_nxt;
    logic [IDX_W-1:0]        r_idx, w_idx_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic [4*NUM_DIGITS-1:0] r_data, w_data_nxt;
    logic [NUM_DIGITS-1:0]   r_dp, w_dp_nxt;
    logic [NUM_DIGITS-1:0]   r_en, w_en_nxt;
    logic                    r_tick_d;
    logic                    r_fs, w_fs_nxt;
    logic [NUM_DIGITS-1:0]   r_an_n, w_an_nxt;
    logic [6:0]              r_seg_n, w_seg_nxt;
    logic                    r_dp_n, w_dpn_nxt;
    logic                    w_edge;
    logic                    w_found;
    logic [IDX_W-1:0]        w_above;
    logic [IDX_W-1:0]        w_low;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    assign w_edge = tick_in & ~r_tick_d;

    // Next state, plus the pin drive for that state so the outputs come straight from flops
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_dp_nxt    = r_dp;
        w_en_nxt    = r_en;
        w_fs_nxt    = 1'b0;
        w_found     = 1'b0;
        w_above     = '0;
        w_low       = '0;
        w_an_nxt    = '1;
        w_seg_nxt   = 7'h7F;
        w_dpn_nxt   = 1'b1;

        // Descending scan so the lowest qualifying bit is the one left standing
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (r_en[i] && (IDX_W'(i) > r_idx)) begin
                w_found = 1'b1;
                w_above = IDX_W'(i);
            end
            if (bus.digit_en[i]) begin
                w_low = IDX_W'(i);
            end
        end

        unique case (r_state)
            S_SHOW, S_DARK: begin
                if (w_edge) begin
                    w_state_nxt = S_BLANK;
                    w_cnt_nxt   = CNT_MAX;
                end
            end
            S_BLANK: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (w_found) begin
                    w_idx_nxt   = w_above;
                    w_state_nxt = S_SHOW;
                end else begin
                    w_data_nxt = bus.data;
                    w_dp_nxt   = bus.dp;
                    w_en_nxt   = bus.digit_en;
                    if (bus.digit_en != '0) begin
                        w_idx_nxt   = w_low;
                        w_state_nxt = S_SHOW;
                        w_fs_nxt    = 1'b1;
                    end else begin
                        w_idx_nxt   = IDX_LAST;
                        w_state_nxt = S_DARK;
                    end
                end
            end
            default: begin
                w_state_nxt = S_BLANK;
                w_cnt_nxt   = CNT_MAX;
            end
        endcase

        if (w_state_nxt == S_SHOW) begin
            w_an_nxt[w_idx_nxt] = 1'b0;
            w_seg_nxt           = hex7(w_data_nxt[{w_idx_nxt, 2'b00} +: 4]);
            w_dpn_nxt           = ~w_dp_nxt[w_idx_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_BLANK;
            r_idx    <= IDX_LAST;
            r_cnt    <= CNT_MAX;
            r_data   <= '0;
            r_dp     <= '0;
            r_en     <= '0;
            r_tick_d <= 1'b0;
            r_fs     <= 1'b0;
            r_an_n   <= '1;
            r_seg_n  <= 7'h7F;
            r_dp_n   <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_data   <= w_data_nxt;
            r_dp     <= w_dp_nxt;
            r_en     <= w_en_nxt;
            r_tick_d <= tick_in;
            r_fs     <= w_fs_nxt;
            r_an_n   <= w_an_nxt;
            r_seg_n  <= w_seg_nxt;
            r_dp_n   <= w_dpn_nxt;
        end
    end

    assign bus.an_n       = r_an_n;
    assign bus.seg_n      = r_seg_n;
    assign bus.dp_n       = r_dp_n;
    assign bus.frame_sync = r_fs;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame-level model predicts each lit
// digit and its onset cycle; a monitor checks every digit as it lights.
module tb_seg_scan_driver;
    localparam int unsigned ND = 4;
    localparam int unsigned BC = 2;

    typedef struct {
        logic [ND-1:0] an;
        logic [6:0]    seg;
        logic          dpn;
        logic          fs;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_in = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Frame-level model state
    int            m_idx;
    logic [ND-1:0] m_en;
    logic [4*ND-1:0] m_data;
    logic [ND-1:0] m_dp;
    bit            m_dark;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg_scan_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_driver #(.NUM_DIGITS(ND), .BLANK_CYC(BC)) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push_digit(input int d, input bit fs, input int when);
        exp_t e;
        e.an      = '1;
        e.an[d]   = 1'b0;
        e.seg     = HEX[m_data[4*d +: 4]];
        e.dpn     = ~m_dp[d];
        e.fs      = fs;
        e.cyc     = when;
        q.push_back(e);
    endtask

    task automatic model_reset();
        m_idx  = ND - 1;
        m_en   = '0;
        m_data = '0;
        m_dp   = '0;
        m_dark = 1'b0;
    endtask

    // Next digit in the latched frame, or a new frame taken from the live inputs
    task automatic model_advance(input int when);
        int nxt;
        nxt = -1;
        for (int i = m_idx + 1; i < int'(ND); i++)
            if (m_en[i] && nxt < 0) nxt = i;
        if (nxt >= 0) begin
            m_idx = nxt;
            push_digit(nxt, 1'b0, when);
        end else begin
            m_data = bus.data;
            m_dp   = bus.dp;
            m_en   = bus.digit_en;
            if (m_en == '0) begin
                m_dark = 1'b1;
                m_idx  = ND - 1;
            end else begin
                m_dark = 1'b0;
                for (int i = ND - 1; i >= 0; i--)
                    if (m_en[i]) m_idx = i;
                push_digit(m_idx, 1'b1, when);
            end
        end
    endtask

    task automatic do_tick(input int settle);
        @(negedge clk);
        tick_in = 1'b1;
        model_advance(cyc + 1 + BC);
        @(negedge clk);
        tick_in = 1'b0;
        repeat (BC + 2 + settle) @(negedge clk);
    endtask

    // Monitor: pops an expectation at each dark-to-lit transition
    initial begin
        bit   prev_lit;
        bit   lit;
        exp_t cur;
        prev_lit = 1'b0;
        cur.an = '1; cur.seg = 7'h7F; cur.dpn = 1'b1; cur.fs = 1'b0; cur.cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            lit = (bus.an_n != '1);
            if (lit && !prev_lit) begin
                if (q.size() == 0) begin
                    chk("unexpected_lit", 32'(bus.an_n), 32'({ND{1'b1}}));
                end else begin
                    cur = q.pop_front();
                    chk("an_n", 32'(bus.an_n), 32'(cur.an));
                    chk("seg_n", 32'(bus.seg_n), 32'(cur.seg));
                    chk("dp_n", 32'(bus.dp_n), 32'(cur.dpn));
                    chk("frame_sync", 32'(bus.frame_sync), 32'(cur.fs));
                    chk("lit_cycle", 32'(cyc), 32'(cur.cyc));
                end
            end else if (lit) begin
                chk("hold_an_n", 32'(bus.an_n), 32'(cur.an));
                chk("hold_seg_n", 32'(bus.seg_n), 32'(cur.seg));
                chk("hold_fs", 32'(bus.frame_sync), 32'(0));
            end else begin
                chk("blank_seg_n", 32'(bus.seg_n), 32'(7'h7F));
                chk("blank_dp_n", 32'(bus.dp_n), 32'(1));
                chk("blank_fs", 32'(bus.frame_sync), 32'(0));
            end
            prev_lit = lit;
        end
    end

    initial begin
        int n;
        bus.data     = 16'h1234;
        bus.dp       = '0;
        bus.digit_en = 4'hF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an_n", 32'(bus.an_n), 32'(4'hF));
        chk("rst_seg_n", 32'(bus.seg_n), 32'(7'h7F));
        chk("rst_dp_n", 32'(bus.dp_n), 32'(1));
        chk("rst_fs", 32'(bus.frame_sync), 32'(0));

        // Release reset: first frame latches BC cycles later
        @(negedge clk);
        rst = 1'b0;
        model_advance(cyc + BC);
        repeat (BC + 4) @(negedge clk);

        // Walk all four digits and wrap
        for (int k = 0; k < 4; k++) do_tick(6);

        // Sparse mask, then a mid-frame change that waits for the wrap
        bus.digit_en = 4'b1010;
        bus.dp       = 4'b0100;
        for (int k = 0; k < 3; k++) do_tick(2);
        bus.digit_en = 4'hF;
        for (int k = 0; k < 5; k++) do_tick(1);

        // Empty mask goes dark, then recovers
        bus.digit_en = 4'h0;
        n = 0;
        while (!m_dark && n < 8) begin
            do_tick(1);
            n++;
        end
        chk("dark_reached", 32'(m_dark), 32'(1));
        chk("dark_an_n", 32'(bus.an_n), 32'(4'hF));
        chk("dark_seg_n", 32'(bus.seg_n), 32'(7'h7F));
        do_tick(3);
        bus.digit_en = 4'h1;
        do_tick(2);
        do_tick(2);

        // Tick held high: one advance only
        bus.digit_en = 4'hF;
        @(negedge clk);
        tick_in = 1'b1;
        model_advance(cyc + 1 + BC);
        repeat (50) @(negedge clk);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);

        // Second edge lands inside the blanking gap and must be ignored
        @(negedge clk);
        tick_in = 1'b1;
        model_advance(cyc + 1 + BC);
        @(negedge clk);
        tick_in = 1'b0;
        @(negedge clk);
        tick_in = 1'b1;
        @(negedge clk);
        tick_in = 1'b0;
        repeat (BC + 4) @(negedge clk);

        // Randomised frames
        for (int k = 0; k < 40; k++) begin
            bus.data     = 16'($urandom);
            bus.dp       = 4'($urandom);
            bus.digit_en = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            do_tick($urandom_range(0, 4));
        end

        // Reset while digit 2 is lit, restart with fresh data
        bus.data     = 16'h1234;
        bus.dp       = '0;
        bus.digit_en = 4'hF;
        n = 0;
        while (!(m_idx == 2 && !m_dark && m_en[2]) && n < 12) begin
            do_tick(1);
            n++;
        end
        chk("digit2_lit", 32'(bus.an_n), 32'(4'b1011));
        @(negedge clk);
        rst      = 1'b1;
        bus.data = 16'hFFFF;
        @(posedge clk);
        #1;
        chk("mid_rst_an_n", 32'(bus.an_n), 32'(4'hF));
        chk("mid_rst_seg_n", 32'(bus.seg_n), 32'(7'h7F));
        chk("mid_rst_dp_n", 32'(bus.dp_n), 32'(1));
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        model_advance(cyc + BC);
        repeat (BC + 3) @(negedge clk);
        chk("restart_seg_n", 32'(bus.seg_n), 32'(7'h0E));
        do_tick(2);

        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", 32'(q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
